// File: rtl/apb_master_mux_pkg.sv
// Shared types and widths for the APB master bridge: FSM state, response record,
// default widths and a helper that sizes the slave index field.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam int DW_MAX   = 32;
  localparam int NSLV_DEF = 4;
  localparam int DW_DEF   = 32;
  localparam int SELW     = $clog2(NSLV_DEF);
  localparam int STRBW    = DW_DEF / 8;

  typedef struct packed {
    logic [DW_MAX-1:0] rdata;
    logic              err;
  } rsp_t;

  // A single slave still needs a 1-bit index to keep vector declarations legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_mux_if.sv
// Command/response and APB segment signals of the APB master bridge.
// The master modport is the bridge's view; slave is the command source / peripheral view.
interface apb_master_mux_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NSLV = 4
);
  localparam int STRBW = DW / 8;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [AW-1:0]      cmd_addr;
  logic [DW-1:0]      cmd_wdata;
  logic [STRBW-1:0]   cmd_strb;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;
  logic [NSLV-1:0]    PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [AW-1:0]      PADDR;
  logic [DW-1:0]      PWDATA;
  logic [STRBW-1:0]   PSTRB;
  logic [NSLV-1:0]    PREADY;
  logic [NSLV*DW-1:0] PRDATA;
  logic [NSLV-1:0]    PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

endinterface

// File: rtl/apb_master_mux_decode.sv
// Combinational address decode: slave index field -> one-hot select plus an
// out-of-range flag for indices that have no slave behind them.
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 12
) (
  input  logic [AW-1:0]   addr,
  output logic [NSLV-1:0] sel,
  output logic            dec_err
);
  localparam int IW = sel_width(NSLV);

  logic [IW-1:0] idx;
  logic          unused_addr_bits;

  if (NSLV > 1) begin : g_multi
    assign idx = addr[SLV_LSB +: IW];
  end else begin : g_single
    assign idx = '0;
  end

  assign unused_addr_bits = ^addr;

  always_comb begin
    sel = '0;
    for (int i = 0; i < NSLV; i++) sel[i] = (idx == IW'(i));
    dec_err = ~|sel;
  end

endmodule

// File: rtl/apb_master_mux.sv
// APB master bridge: valid/ready commands -> SETUP/ACCESS transfers on NSLV slaves.
// Optional ACCESS timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_mux
  import apb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NSLV    = 4,
  parameter int SLV_LSB = 12,
  parameter int TO_CYC  = 256
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_mux_if.master    bus
);
  localparam int SW = DW / 8;

  state_t          state_q, state_d;
  logic [NSLV-1:0] dec_sel, sel_q;
  logic            dec_err, accept, pready_sel, pslverr_sel, timeout;
  logic [DW-1:0]   prdata_sel;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   strb_q;
  logic            write_q;
  logic            rsp_valid_q;
  rsp_t            rsp_q;

  apb_slave_decode #(.AW(AW), .NSLV(NSLV), .SLV_LSB(SLV_LSB)) u_decode (
    .addr    (bus.cmd_addr),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  assign accept = bus.cmd_valid && (state_q == IDLE);

  // Only the selected slave's response lines are observed.
  always_comb begin
    prdata_sel = '0;
    for (int i = 0; i < NSLV; i++)
      if (sel_q[i]) prdata_sel = prdata_sel | bus.PRDATA[i*DW +: DW];
  end
  assign pready_sel  = |(bus.PREADY & sel_q);
  assign pslverr_sel = |(bus.PSLVERR & sel_q);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt_q;

  // PREADY in the final counted cycle still completes the transfer normally.
  assign timeout = (state_q == ACCESS) && !pready_sel && (to_cnt_q == TW'(TO_CYC - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                              to_cnt_q <= '0;
    else if (state_q == SETUP)                 to_cnt_q <= '0;
    else if (state_q == ACCESS && !pready_sel) to_cnt_q <= to_cnt_q + 1'b1;
  end
`else
  localparam int to_cyc_unused = TO_CYC;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !dec_err) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_sel || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == IDLE);
    bus.PSEL      = (state_q == IDLE) ? '0 : sel_q;
    bus.PENABLE   = (state_q == ACCESS);
  end

  // Transfer attributes are frozen at acceptance and held through IDLE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
    end else if (accept && !dec_err) begin
      addr_q  <= bus.cmd_addr;
      wdata_q <= bus.cmd_wdata;
      strb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
      write_q <= bus.cmd_write;
      sel_q   <= dec_sel;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept && dec_err) begin
        rsp_valid_q <= 1'b1;
        rsp_q       <= '{rdata: '0, err: 1'b1};
      end else if (state_q == ACCESS && pready_sel) begin
        rsp_valid_q <= 1'b1;
        rsp_q.rdata <= (write_q || pslverr_sel) ? '0 : DW_MAX'(prdata_sel);
        rsp_q.err   <= pslverr_sel;
      end else if (timeout) begin
        rsp_valid_q <= 1'b1;
        rsp_q       <= '{rdata: '0, err: 1'b1};
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata[DW-1:0];
  assign bus.rsp_err   = rsp_q.err;
  assign bus.PADDR     = addr_q;
  assign bus.PWDATA    = wdata_q;
  assign bus.PSTRB     = strb_q;
  assign bus.PWRITE    = write_q;

endmodule
